imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath ID stage; successor to the combinational 16->32 sign extender.
- Accepts an IN_W-bit immediate plus a mode select and produces an OUT_W-bit operand.
- Modes: sign-extend, zero-extend, upper-load (LUI), and branch-offset (sign-extend then shift left 2).
- Valid/ready handshaked on both sides, with a 2-entry output buffer so backpressure from EX never loses data; synchronous flush for branch/exception squash.

Parameters:
- IN_W, 16, immediate input width; must be >= 2.
- OUT_W, 32, result width; must satisfy OUT_W >= IN_W + 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an immediate.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode (see Behaviour).
- flush  in  1  synchronous squash of all buffered results.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  OUT_W  extended immediate.
- out_mode  out  2  mode that produced out_data (for EX-side checks).

Behaviour:
- Reset (rst_n=0, asynchronous): buffer count=0, write/read pointers=0, out_valid=0, in_ready=1, out_data=0, out_mode=0.
  - Takes effect immediately, mid-transfer included; in-flight entries are discarded.
- Modes (in_mode):
  - 0 SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - 1 ZERO: {(OUT_W-IN_W){0}, imm}.
  - 2 LUI: imm placed in the top IN_W bits, low OUT_W-IN_W bits zero.
  - 3 SHL2: sign-extend to OUT_W, then shift left 2; the two MSBs shifted out are dropped.
- Extension is computed combinationally from in_imm/in_mode and written into the buffer on accept.
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Buffer: 2-entry circular FIFO storing {mode, data}; count range 0..2.
  - in_ready = (count != 2); derived from registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0); out_data/out_mode show the head entry; out_data=0 and out_mode=0 when empty.
- Latency: a value accepted at edge N appears on out_data after edge N when the buffer was empty, i.e. one cycle.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous push & pop: count unchanged, both pointers advance.
  - At count=1, the head pops and the new entry becomes head on the next cycle.
- Full (count=2): in_ready=0, in_valid is ignored, nothing is overwritten. Popping while full leaves in_ready=1 on the next cycle.
- Empty: out_ready is ignored; no underflow, pointers hold.
- Pointer wrap: 1-bit pointers wrap 1->0.
- flush=1 at an edge: count=0, pointers=0, out_valid=0 next cycle.
  - flush has priority over a same-cycle push and pop; an accepted input in the flush cycle is discarded.
  - in_ready is still driven by the pre-flush count during the flush cycle.
- Inputs do not need to be stable when in_valid=0; there is no X-propagation into the buffer.

Decomposition:
- Shared package ext_pkg holds the mode constants EXT_SIGN=2'd0, EXT_ZERO=2'd1, EXT_LUI=2'd2, EXT_SHL2=2'd3 and the mode width (2). The decoder uses the same constants.
- Sub-module imm_ext_core (combinational, parameters IN_W/OUT_W) implements the four modes.
  - It is reused by imm_ext_pipe and tested standalone.
- imm_ext_pipe holds only the FIFO, handshake and flush logic.

Test Plan:
- Reset then SIGN with in_imm 0x0001 -> 0x00000001; 0xFFFF -> 0xFFFFFFFF; 0x0002 -> 0x00000002; 0xFFFE -> 0xFFFFFFFE; each result valid one cycle after accept.
- 0xFFFF through ZERO -> 0x0000FFFF, LUI -> 0xFFFF0000, SHL2 -> 0xFFFFFFFC; 0x8000 SHL2 -> 0xFFFE0000; out_mode matches each input mode.
- out_ready=0, offer 3 back-to-back -> in_ready falls after 2 accepts, 3rd held; raise out_ready -> 3 results in order, none lost or duplicated.
- Continuous stream of 8 with out_ready=1 -> 1 result/cycle, count stays <=1, pointers wrap correctly.
- Buffer holding 2 entries, assert flush with in_valid=1 -> out_valid=0 next cycle, flushed-cycle input absent, next accept appears with 1-cycle latency.
- Drop rst_n asynchronously between edges with 2 buffered -> out_valid=0 and in_ready=1 immediately; release and resume normal operation.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared mode encoding for the immediate extender and the ID-stage decoder.
package ext_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t EXT_SIGN = 2'd0;
    localparam mode_t EXT_ZERO = 2'd1;
    localparam mode_t EXT_LUI  = 2'd2;
    localparam mode_t EXT_SHL2 = 2'd3;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bus between the ID-stage decoder, the extension unit and EX.
interface imm_ext_pipe_if
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    mode_t            in_mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    mode_t            out_mode;

    modport master (
        output in_valid, in_imm, in_mode, flush, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_imm, in_mode, flush, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: sign, zero, upper-load and branch-offset modes.
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  mode_t            mode,
    output logic [OUT_W-1:0] data
);
    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W - IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        data = sext;
        unique case (mode)
            EXT_SIGN: data = sext;
            EXT_ZERO: data = {{(OUT_W - IN_W){1'b0}}, imm};
            EXT_LUI:  data = {imm, {(OUT_W - IN_W){1'b0}}};
            EXT_SHL2: data = sext << 2;
            default:  data = sext;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: extension on accept into a 2-entry FIFO with
// valid/ready on both sides and a synchronous squash.
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    imm_ext_pipe_if.slave bus
);
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] data_q [2];
    mode_t            mode_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (bus.in_imm),
        .mode (bus.in_mode),
        .data (ext_data)
    );

    // Ready depends only on registered count, so EX backpressure never reaches ID combinationally.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = bus.out_valid ? data_q[rd_ptr_q] : '0;
    assign bus.out_mode  = bus.out_valid ? mode_q[rd_ptr_q] : EXT_SIGN;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                mode_q[i] <= EXT_SIGN;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (bus.flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= ext_data;
                mode_q[wr_ptr_q] <= bus.in_mode;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: vector table for the extension modes plus
// hand-written backpressure, flush and asynchronous reset sequences.
module tb_imm_ext_pipe;
    import ext_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

    imm_ext_pipe #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        mode_t       mode;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] imm, input mode_t mode);
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = EXT_SIGN;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{16'h0001, EXT_SIGN, 32'h0000_0001};
        vecs[1] = '{16'hFFFF, EXT_SIGN, 32'hFFFF_FFFF};
        vecs[2] = '{16'h0002, EXT_SIGN, 32'h0000_0002};
        vecs[3] = '{16'hFFFE, EXT_SIGN, 32'hFFFF_FFFE};
        vecs[4] = '{16'hFFFF, EXT_ZERO, 32'h0000_FFFF};
        vecs[5] = '{16'hFFFF, EXT_LUI,  32'hFFFF_0000};
        vecs[6] = '{16'hFFFF, EXT_SHL2, 32'hFFFF_FFFC};
        vecs[7] = '{16'h8000, EXT_SHL2, 32'hFFFE_0000};

        #12;
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset out_mode", {30'd0, bus.out_mode}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream with out_ready=1: each result appears one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            offer(vecs[i].imm, vecs[i].mode);
            check($sformatf("stream[%0d] in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            tick();
            check($sformatf("stream[%0d] out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("stream[%0d] out_data", i), bus.out_data, vecs[i].exp_data);
            check($sformatf("stream[%0d] out_mode", i), {30'd0, bus.out_mode},
                  {30'd0, vecs[i].mode});
        end
        bus.in_valid = 1'b0;
        tick();
        check("drain out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drain out_data", bus.out_data, 32'd0);

        // Backpressure: third offer held while full, then three results in order.
        bus.out_ready = 1'b0;
        offer(16'h1111, EXT_ZERO);
        tick();
        offer(16'h2222, EXT_LUI);
        check("bp second in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        offer(16'h3333, EXT_SIGN);
        check("bp full in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("bp held in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp held head", bus.out_data, 32'h0000_1111);
        bus.out_ready = 1'b1;
        tick();
        check("bp after pop in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp second out", bus.out_data, 32'h2222_0000);
        check("bp second mode", {30'd0, bus.out_mode}, {30'd0, EXT_LUI});
        tick();
        bus.in_valid = 1'b0;
        check("bp third out", bus.out_data, 32'h0000_3333);
        check("bp third valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("bp empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush while full with an offered input.
        bus.out_ready = 1'b0;
        offer(16'h0AAA, EXT_SIGN);
        tick();
        offer(16'h0BBB, EXT_SIGN);
        tick();
        offer(16'h0CCC, EXT_SIGN);
        bus.flush = 1'b1;
        check("flush in_ready pre", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        check("flush full out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush full in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Flush at count=1 with an accepted push: the push must be discarded.
        offer(16'h0DDD, EXT_SIGN);
        tick();
        offer(16'h0EEE, EXT_SIGN);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush push out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        offer(16'h7FFF, EXT_SHL2);
        tick();
        bus.in_valid = 1'b0;
        check("post flush out_data", bus.out_data, 32'h0001_FFFC);
        check("post flush out_mode", {30'd0, bus.out_mode}, {30'd0, EXT_SHL2});
        tick();
        check("post flush drained", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset between edges with two entries buffered.
        bus.out_ready = 1'b0;
        offer(16'h1234, EXT_ZERO);
        tick();
        offer(16'h5678, EXT_ZERO);
        tick();
        bus.in_valid = 1'b0;
        check("pre areset in_ready", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("areset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("areset out_data", bus.out_data, 32'd0);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        offer(16'hC000, EXT_SIGN);
        tick();
        bus.in_valid = 1'b0;
        check("resume out_data", bus.out_data, 32'hFFFF_C000);
        check("resume out_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("resume drained", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
